// File: rtl/collector_pkg.sv
`default_nettype none
// ============================================================================
// Module : collector_pkg
// Brief  : Shared types and default sizes for dual_result_collector.
// Rev    : 1.0  initial release
// ============================================================================
package collector_pkg;

    typedef enum logic [0:0] {
        LANE_P1 = 1'b0,
        LANE_P2 = 1'b1
    } lane_e;

    typedef enum logic [0:0] {
        LAST_P1 = 1'b0,
        LAST_P2 = 1'b1
    } arb_state_e;

    localparam int c_data_w = 32;
    localparam int c_depth  = 4;
    localparam int c_cnt_w  = 16;

endpackage : collector_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module : sync_fifo
// Brief  : Single-clock FIFO; a write while full succeeds if a read happens too.
// Rev    : 1.0  initial release
// ============================================================================
module sync_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] din,
    input  logic              rd_en,
    output logic              full,
    output logic              empty,
    output logic [DATA_W-1:0] dout
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam logic [c_ptr_w:0] c_full_occ = (c_ptr_w + 1)'(DEPTH);

    logic [DATA_W-1:0]  r_mem [DEPTH];
    logic [c_ptr_w-1:0] r_wr_ptr;
    logic [c_ptr_w-1:0] r_rd_ptr;
    logic [c_ptr_w:0]   r_occ;
    logic               w_wr;
    logic               w_rd;

    assign full  = (r_occ == c_full_occ);
    assign empty = (r_occ == '0);
    assign dout  = r_mem[r_rd_ptr];
    assign w_rd  = rd_en && !empty;
    assign w_wr  = wr_en && (!full || w_rd);

    always_ff @(posedge clk) begin
        if (w_wr) begin
            r_mem[r_wr_ptr] <= din;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_wr) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_wr && !w_rd) begin
                r_occ <= r_occ + 1'b1;
            end else if (w_rd && !w_wr) begin
                r_occ <= r_occ - 1'b1;
            end
        end
    end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/dual_result_collector.sv
`default_nettype none
// ============================================================================
// Module : dual_result_collector
// Brief  : Buffers two result lanes and merges them round-robin with stats.
// Rev    : 1.0  initial release
// ============================================================================
module dual_result_collector
    import collector_pkg::*;
#(
    parameter int DATA_W = c_data_w,
    parameter int DEPTH  = c_depth,
    parameter int CNT_W  = c_cnt_w
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] pipeline1_outputs,
    input  logic [DATA_W-1:0] pipeline2_outputs,
    input  logic [1:0]        valid,
    output logic [DATA_W-1:0] m_data,
    output logic              m_src,
    output logic              m_valid,
    input  logic              m_ready,
    output logic [CNT_W-1:0]  count1,
    output logic [CNT_W-1:0]  count2,
    output logic [CNT_W-1:0]  drop_count,
    output logic              overflow,
    output logic [DATA_W-1:0] checksum
);

    function automatic logic [CNT_W-1:0] f_sat_add(input logic [CNT_W-1:0] a,
                                                   input logic [1:0] inc);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(inc);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    logic              w_full1, w_full2, w_empty1, w_empty2;
    logic [DATA_W-1:0] w_dout1, w_dout2;
    logic              w_acc1, w_acc2, w_drop1, w_drop2;
    logic              w_pop1, w_pop2, w_load;
    lane_e             w_grant;
    arb_state_e        r_state, w_state_next;

    logic [DATA_W-1:0] r_m_data;
    lane_e             r_m_src;
    logic              r_m_valid;
    logic [CNT_W-1:0]  r_count1, r_count2, r_drop_count;
    logic              r_overflow;
    logic [DATA_W-1:0] r_checksum;

    // A full lane still accepts when the arbiter pops it this same cycle.
    assign w_acc1  = valid[0] && (!w_full1 || w_pop1);
    assign w_acc2  = valid[1] && (!w_full2 || w_pop2);
    assign w_drop1 = valid[0] && !w_acc1;
    assign w_drop2 = valid[1] && !w_acc2;

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo1 (
        .clk(clk), .reset(reset), .wr_en(w_acc1), .din(pipeline1_outputs),
        .rd_en(w_pop1), .full(w_full1), .empty(w_empty1), .dout(w_dout1)
    );

    sync_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo2 (
        .clk(clk), .reset(reset), .wr_en(w_acc2), .din(pipeline2_outputs),
        .rd_en(w_pop2), .full(w_full2), .empty(w_empty2), .dout(w_dout2)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= LAST_P2;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (w_load) begin
            w_state_next = (w_grant == LANE_P1) ? LAST_P1 : LAST_P2;
        end
    end

    always_comb begin
        w_load  = (!r_m_valid || m_ready) && (!w_empty1 || !w_empty2);
        w_grant = LANE_P1;
        if (!w_empty1 && !w_empty2) begin
            w_grant = (r_state == LAST_P1) ? LANE_P2 : LANE_P1;
        end else if (w_empty1) begin
            w_grant = LANE_P2;
        end
        w_pop1 = w_load && (w_grant == LANE_P1);
        w_pop2 = w_load && (w_grant == LANE_P2);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_m_data   <= '0;
            r_m_src    <= LANE_P1;
            r_m_valid  <= 1'b0;
            r_checksum <= '0;
        end else begin
            if (r_m_valid && m_ready) begin
                r_checksum <= r_checksum ^ r_m_data;
            end
            if (w_load) begin
                r_m_data  <= (w_grant == LANE_P1) ? w_dout1 : w_dout2;
                r_m_src   <= w_grant;
                r_m_valid <= 1'b1;
            end else if (m_ready) begin
                r_m_valid <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count1     <= '0;
            r_count2     <= '0;
            r_drop_count <= '0;
            r_overflow   <= 1'b0;
        end else begin
            r_count1     <= f_sat_add(r_count1, {1'b0, w_acc1});
            r_count2     <= f_sat_add(r_count2, {1'b0, w_acc2});
            r_drop_count <= f_sat_add(r_drop_count, {1'b0, w_drop1} + {1'b0, w_drop2});
            r_overflow   <= r_overflow | w_drop1 | w_drop2;
        end
    end

    assign m_data     = r_m_data;
    assign m_src      = r_m_src;
    assign m_valid    = r_m_valid;
    assign count1     = r_count1;
    assign count2     = r_count2;
    assign drop_count = r_drop_count;
    assign overflow   = r_overflow;
    assign checksum   = r_checksum;

endmodule : dual_result_collector
`default_nettype wire

// File: tb/tb_dual_result_collector.sv
`default_nettype none
// ============================================================================
// Module : tb_dual_result_collector
// Brief  : Directed scenarios plus random traffic against a queue-level model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_dual_result_collector;

    localparam int c_depth = 4;
    localparam int c_cmax  = 65535;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pipeline1_outputs = '0;
    logic [31:0] pipeline2_outputs = '0;
    logic [1:0]  valid = '0;
    logic        m_ready = 1'b0;
    logic [31:0] m_data;
    logic        m_src;
    logic        m_valid;
    logic [15:0] count1, count2, drop_count;
    logic        overflow;
    logic [31:0] checksum;

    int total = 0;
    int bad   = 0;

    // Reference model: lane queues, one output slot, last-granted lane.
    logic [31:0] mq1[$];
    logic [31:0] mq2[$];
    bit          mv;
    logic [31:0] md;
    bit          ms;
    bit          mlast;
    int          mc1, mc2, mcd;
    bit          mov;
    logic [31:0] mck;

    dual_result_collector dut (
        .clk(clk), .reset(reset),
        .pipeline1_outputs(pipeline1_outputs), .pipeline2_outputs(pipeline2_outputs),
        .valid(valid), .m_data(m_data), .m_src(m_src), .m_valid(m_valid),
        .m_ready(m_ready), .count1(count1), .count2(count2),
        .drop_count(drop_count), .overflow(overflow), .checksum(checksum)
    );

    always #5 clk = ~clk;

    task automatic model_step();
        bit g;
        if (reset) begin
            mq1.delete(); mq2.delete();
            mv = 0; md = '0; ms = 0; mlast = 1;
            mc1 = 0; mc2 = 0; mcd = 0; mov = 0; mck = '0;
        end else begin
            if (mv && m_ready) mck = mck ^ md;
            if ((!mv || m_ready) && (mq1.size() > 0 || mq2.size() > 0)) begin
                if (mq1.size() > 0 && mq2.size() > 0) g = !mlast;
                else g = (mq1.size() == 0);
                md = g ? mq2.pop_front() : mq1.pop_front();
                ms = g; mv = 1; mlast = g;
            end else if (m_ready) begin
                mv = 0;
            end
            if (valid[0]) begin
                if (mq1.size() < c_depth) begin
                    mq1.push_back(pipeline1_outputs);
                    if (mc1 < c_cmax) mc1++;
                end else begin
                    if (mcd < c_cmax) mcd++;
                    mov = 1;
                end
            end
            if (valid[1]) begin
                if (mq2.size() < c_depth) begin
                    mq2.push_back(pipeline2_outputs);
                    if (mc2 < c_cmax) mc2++;
                end else begin
                    if (mcd < c_cmax) mcd++;
                    mov = 1;
                end
            end
        end
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        valid = 2'b00;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        m_ready = 1'b1;
        do_reset();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL reset_m_valid got=%0b want=0", m_valid); end
        total++; if (m_data !== 32'h0) begin bad++; $display("FAIL reset_m_data got=%h want=0", m_data); end
        total++; if ({count1, count2, drop_count} !== 48'h0) begin bad++; $display("FAIL reset_counts got=%h/%h/%h want=0", count1, count2, drop_count); end
        total++; if ({overflow, checksum} !== 33'h0) begin bad++; $display("FAIL reset_ovf_cks got=%b/%h want=0", overflow, checksum); end
    endtask

    task automatic test_single();
        do_reset();
        m_ready = 1'b1;
        valid = 2'b01;
        pipeline1_outputs = 32'hA5A5_0001;
        tick();
        valid = 2'b00;
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_early got=%0b want=0", m_valid); end
        tick();
        total++; if (m_valid !== 1'b1) begin bad++; $display("FAIL single_valid got=%0b want=1", m_valid); end
        total++; if (m_data !== 32'hA5A5_0001 || m_src !== 1'b0) begin bad++; $display("FAIL single_data got=%h/%0b want=a5a50001/0", m_data, m_src); end
        total++; if (count1 !== 16'd1) begin bad++; $display("FAIL single_count1 got=%0d want=1", count1); end
        tick();
        total++; if (checksum !== 32'hA5A5_0001) begin bad++; $display("FAIL single_checksum got=%h want=a5a50001", checksum); end
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL single_clear got=%0b want=0", m_valid); end
    endtask

    task automatic test_interleave();
        logic [31:0] exp_d [8] = '{32'h1, 32'h11, 32'h2, 32'h12, 32'h3, 32'h13, 32'h4, 32'h14};
        logic [31:0] got_d [8];
        logic        got_s [8];
        int n = 0;
        do_reset();
        m_ready = 1'b1;
        valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            pipeline1_outputs = 32'(i + 1);
            pipeline2_outputs = 32'(32'h11 + i);
            tick();
            if (m_valid && n < 8) begin got_d[n] = m_data; got_s[n] = m_src; n++; end
        end
        valid = 2'b00;
        for (int t = 0; t < 20 && n < 8; t++) begin
            tick();
            if (m_valid && n < 8) begin got_d[n] = m_data; got_s[n] = m_src; n++; end
        end
        total++;
        if (n != 8) begin
            bad++; $display("FAIL interleave_timeout got=%0d words want=8", n);
        end else begin
            for (int i = 0; i < 8; i++) begin
                total++;
                if (got_d[i] !== exp_d[i] || got_s[i] !== 1'(i % 2)) begin
                    bad++; $display("FAIL interleave_word%0d got=%h/%0b want=%h/%0d", i, got_d[i], got_s[i], exp_d[i], i % 2);
                end
            end
        end
        total++; if (drop_count !== 16'd0) begin bad++; $display("FAIL interleave_drops got=%0d want=0", drop_count); end
    endtask

    task automatic test_overflow();
        do_reset();
        m_ready = 1'b0;
        valid = 2'b01;
        for (int i = 0; i < 7; i++) begin
            pipeline1_outputs = 32'(32'h100 + i);
            tick();
        end
        valid = 2'b00;
        total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL ovf_drops got=%0d want=2", drop_count); end
        total++; if (overflow !== 1'b1) begin bad++; $display("FAIL ovf_flag got=%0b want=1", overflow); end
        total++; if (count1 !== 16'd5) begin bad++; $display("FAIL ovf_count1 got=%0d want=5", count1); end
        total++; if (m_valid !== 1'b1 || m_data !== 32'h100) begin bad++; $display("FAIL ovf_head got=%0b/%h want=1/100", m_valid, m_data); end
    endtask

    task automatic test_full_pop();
        logic [31:0] exp_d [4] = '{32'h102, 32'h103, 32'h104, 32'h200};
        int n = 0;
        bit ok = 1;
        m_ready = 1'b1;
        valid = 2'b01;
        pipeline1_outputs = 32'h200;
        tick();
        valid = 2'b00;
        total++; if (drop_count !== 16'd2) begin bad++; $display("FAIL fullpop_drops got=%0d want=2", drop_count); end
        total++; if (count1 !== 16'd6) begin bad++; $display("FAIL fullpop_count1 got=%0d want=6", count1); end
        total++; if (m_data !== 32'h101) begin bad++; $display("FAIL fullpop_head got=%h want=101", m_data); end
        for (int t = 0; t < 10 && n < 4; t++) begin
            tick();
            if (m_valid) begin
                if (m_data !== exp_d[n]) ok = 0;
                n++;
            end
        end
        total++; if (!ok || n != 4) begin bad++; $display("FAIL fullpop_drain got=%0d words ok=%0b want=4 words ok=1", n, ok); end
    endtask

    task automatic test_hold();
        do_reset();
        m_ready = 1'b0;
        valid = 2'b01;
        pipeline1_outputs = 32'hDEAD_0005;
        tick();
        valid = 2'b00;
        pipeline1_outputs = 32'h0;
        tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            total++;
            if (m_valid !== 1'b1 || m_data !== 32'hDEAD_0005 || m_src !== 1'b0) begin
                bad++; $display("FAIL hold_cycle%0d got=%0b/%h/%0b want=1/dead0005/0", i, m_valid, m_data, m_src);
            end
        end
        total++; if (checksum !== 32'h0) begin bad++; $display("FAIL hold_cks_early got=%h want=0", checksum); end
        m_ready = 1'b1;
        tick();
        total++; if (checksum !== 32'hDEAD_0005 || m_valid !== 1'b0) begin bad++; $display("FAIL hold_handoff got=%h/%0b want=dead0005/0", checksum, m_valid); end
        tick();
        total++; if (checksum !== 32'hDEAD_0005) begin bad++; $display("FAIL hold_once got=%h want=dead0005", checksum); end
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        valid = 2'b11;
        for (int i = 0; i < 2; i++) begin
            pipeline1_outputs = 32'(32'h21 + i);
            pipeline2_outputs = 32'(32'h41 + i);
            tick();
        end
        do_reset();
        total++; if (m_valid !== 1'b0) begin bad++; $display("FAIL midrst_valid got=%0b want=0", m_valid); end
        total++; if ({count1, count2, drop_count} !== 48'h0 || overflow !== 1'b0 || checksum !== 32'h0) begin
            bad++; $display("FAIL midrst_stats got=%0d/%0d/%0d/%0b/%h want=0", count1, count2, drop_count, overflow, checksum);
        end
        m_ready = 1'b1;
        valid = 2'b11;
        pipeline1_outputs = 32'h31;
        pipeline2_outputs = 32'h32;
        tick();
        valid = 2'b00;
        tick();
        total++; if (m_valid !== 1'b1 || m_src !== 1'b0 || m_data !== 32'h31) begin bad++; $display("FAIL midrst_tie got=%0b/%0b/%h want=1/0/31", m_valid, m_src, m_data); end
        tick();
        total++; if (m_valid !== 1'b1 || m_src !== 1'b1 || m_data !== 32'h32) begin bad++; $display("FAIL midrst_second got=%0b/%0b/%h want=1/1/32", m_valid, m_src, m_data); end
        tick();
        total++; if (count1 !== 16'd1 || count2 !== 16'd1) begin bad++; $display("FAIL midrst_counts got=%0d/%0d want=1/1", count1, count2); end
    endtask

    task automatic test_random();
        int errs = 0;
        do_reset();
        for (int cyc = 0; cyc < 600; cyc++) begin
            valid = 2'($urandom);
            pipeline1_outputs = $urandom;
            pipeline2_outputs = $urandom;
            m_ready = (cyc < 300) ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 3) != 0);
            tick();
            total++;
            if (m_valid !== mv || (mv && (m_data !== md || m_src !== ms))) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_out cyc=%0d got=%0b/%h/%0b want=%0b/%h/%0b", cyc, m_valid, m_data, m_src, mv, md, ms);
            end
            total++;
            if (count1 !== 16'(mc1) || count2 !== 16'(mc2) || drop_count !== 16'(mcd) || overflow !== mov || checksum !== mck) begin
                bad++; errs++;
                if (errs < 10) $display("FAIL rand_stats cyc=%0d got=%0d/%0d/%0d/%0b/%h want=%0d/%0d/%0d/%0b/%h",
                                        cyc, count1, count2, drop_count, overflow, checksum, mc1, mc2, mcd, mov, mck);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_interleave();
        test_overflow();
        test_full_pop();
        test_hold();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_dual_result_collector
`default_nettype wire
